div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 divider for the RV32M divide group (DIV, DIVU, REM, REMU) in the execute stage. It consumes the decode-stage `div_en` qualifier and `funct3` as they arrive through the ID/EX register. It holds the pipeline with a stall request while it iterates, then presents a 32-bit result for the EX/MEM register. Divide-by-zero and signed-overflow results follow the RISC-V specification, with no trap.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `div_en_e` input 1: a divide-group instruction is in EX this cycle.
- `funct3_e` input 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a_e` input XLEN: dividend (forwarded rs1).
- `op_b_e` input XLEN: divisor (forwarded rs2).
- `flush_e` input 1: EX flush from the hazard unit; aborts any operation.
- `div_stall` output 1: freeze PC, IF/ID and ID/EX this cycle.
- `div_done` output 1: `div_result` is valid this cycle.
- `div_result` output XLEN: quotient or remainder.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values: all registers clear. `div_stall`=0, `div_done`=0, `div_result`=0.
- Transitions:
  - IDLE and `div_en_e` & ~`flush_e`: latch operands, the signed flag (= ~`funct3_e[0]`) and the rem flag (= `funct3_e[1]`), then go to CALC.
  - CALC: one restoring step per cycle on 32-bit magnitudes. A 6-bit counter runs 0..31; after step 31, go to DONE.
  - DONE: drive `div_result`, assert `div_done`, return to IDLE. `div_en_e` is ignored in DONE because the same instruction is still in EX.
- Special cases are detected at latch time. They skip CALC and go IDLE→DONE, so latency is 1.
  - Divisor zero: quotient = all ones, remainder = dividend.
  - Signed overflow (dividend 0x8000_0000, divisor 0xFFFF_FFFF): quotient = 0x8000_0000, remainder = 0.
- Sign rules for signed ops:
  - Magnitudes are taken at latch.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Sign fix is applied combinationally in DONE.
- Stall:
  - `div_stall` = (IDLE & `div_en_e` & ~`flush_e`) | CALC.
  - It is low in DONE, so the pipeline advances on the same edge that retires the result.
- `flush_e` in any state forces IDLE on the next edge. `div_done` is never asserted for a flushed operation.
- `rst_n` low mid-operation clears everything immediately, with no output glitch requirement beyond the reset values.

## Timing
- Normal op: `div_en_e` seen in IDLE at cycle 0, with stall high. CALC runs cycles 1–32 with stall high. DONE is cycle 33, with stall low and `div_done` high.
- Total: 34 cycles in EX, 33 stall cycles.
- Special case: cycle 0 in IDLE with stall high, cycle 1 in DONE.
- Back-to-back divides: the second is accepted in the cycle after DONE (IDLE). There is no dead cycle beyond that.
- `div_result` is combinational from registers in DONE. It is 0 outside DONE.

## Structure
- A shared package `riscv_pkg` holds:
  - `div_state_t` (IDLE/CALC/DONE).
  - `F3_DIV`, `F3_DIVU`, `F3_REM`, `F3_REMU`.
  - `DIV_ITER`=32.
- One natural sub-module, `div_step`, is combinational. It takes partial remainder, quotient and divisor; it shifts in one dividend bit, trial-subtracts, and returns the next remainder and quotient.
- All other logic (FSM, counter, sign fix) stays in `div_unit`.

## Test plan
- DIV 100/7 → `div_result`=14 at cycle 33 with `div_stall` high for cycles 0–32. REM 100/7 → 2.
- DIV -100/7 → 0xFFFF_FFF2 (-14). REM -100/7 → 0xFFFF_FFFE (-2). DIVU 0xFFFF_FFFF/2 → 0x7FFF_FFFF.
- DIV 5/0 → 0xFFFF_FFFF at cycle 1. REMU 5/0 → 5. DIV 0x8000_0000/-1 → 0x8000_0000 at cycle 1. REM of the same operands → 0.
- Back-to-back DIVU 10/3 then REMU 10/3 → 3, then 1. The second is accepted the cycle after the first `div_done`.
- `flush_e` at CALC cycle 10 → IDLE next cycle, `div_stall` low, no `div_done`. `rst_n` low at CALC cycle 20 → all outputs 0 immediately, and the next DIV 9/3 → 3.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the RV32M divide group.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam int DIV_ITER = 32;

endpackage

`default_nettype wire

// File: rtl/div_unit_if.sv
// ============================================================================
// Module      : div_unit_if
// Description : EX-stage divide request/response bundle between pipeline and divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            div_en_e;
  logic [2:0]      funct3_e;
  logic [XLEN-1:0] op_a_e;
  logic [XLEN-1:0] op_b_e;
  logic            flush_e;
  logic            div_stall;
  logic            div_done;
  logic [XLEN-1:0] div_result;

  modport master (
    output div_en_e, funct3_e, op_a_e, op_b_e, flush_e,
    input  div_stall, div_done, div_result
  );

  modport slave (
    input  div_en_e, funct3_e, op_a_e, op_b_e, flush_e,
    output div_stall, div_done, div_result
  );
endinterface

`default_nettype wire

// File: rtl/div_unit_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step on unsigned magnitudes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;

  // quo_in carries the unconsumed dividend bits at its top; the MSB of the
  // 33-bit difference is set exactly when the trial subtraction underflows.
  assign w_shifted = {rem_in, quo_in[XLEN-1]};
  assign w_diff    = w_shifted - {1'b0, divisor};

  always_comb begin
    rem_out = w_shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], 1'b0};
    if (!w_diff[XLEN]) begin
      rem_out = w_diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end
endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module      : div_unit
// Description : Iterative radix-2 DIV/DIVU/REM/REMU unit with pipeline stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  div_unit_if.slave div_if
);
  div_state_t      r_state, w_state_next;
  logic [5:0]      r_cnt;
  logic [XLEN-1:0] r_rem, r_quo, r_divisor;
  logic            r_is_rem, r_neg_q, r_neg_r;

  logic            w_start, w_signed, w_a_neg, w_b_neg, w_div_zero, w_ovf, w_last;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_rem_step, w_quo_step;
  logic            w_unused_f3;

  assign w_unused_f3 = div_if.funct3_e[2];
  assign w_start     = (r_state == IDLE) && div_if.div_en_e && !div_if.flush_e;
  assign w_signed    = ~div_if.funct3_e[0];
  assign w_a_neg     = w_signed & div_if.op_a_e[XLEN-1];
  assign w_b_neg     = w_signed & div_if.op_b_e[XLEN-1];
  assign w_mag_a     = w_a_neg ? (~div_if.op_a_e + 1'b1) : div_if.op_a_e;
  assign w_mag_b     = w_b_neg ? (~div_if.op_b_e + 1'b1) : div_if.op_b_e;
  assign w_div_zero  = (div_if.op_b_e == '0);
  assign w_ovf       = w_signed && (div_if.op_a_e == {1'b1, {(XLEN-1){1'b0}}})
                       && (div_if.op_b_e == '1);
  assign w_last      = (r_cnt == 6'(DIV_ITER - 1));

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .divisor (r_divisor),
    .rem_out (w_rem_step),
    .quo_out (w_quo_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next      = r_state;
    div_if.div_stall  = 1'b0;
    div_if.div_done   = 1'b0;
    div_if.div_result = '0;
    case (r_state)
      IDLE: begin
        div_if.div_stall = w_start;
        if (w_start) w_state_next = (w_div_zero || w_ovf) ? DONE : CALC;
      end
      CALC: begin
        div_if.div_stall = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        div_if.div_done   = ~div_if.flush_e;
        // Sign fix happens here so the registers only ever hold magnitudes.
        if (r_is_rem) div_if.div_result = r_neg_r ? (~r_rem + 1'b1) : r_rem;
        else          div_if.div_result = r_neg_q ? (~r_quo + 1'b1) : r_quo;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (div_if.flush_e) w_state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else if (w_start) begin
      r_cnt     <= '0;
      r_divisor <= w_mag_b;
      r_is_rem  <= div_if.funct3_e[1];
      // Special cases load their final, already-signed answers directly.
      if (w_div_zero) begin
        r_quo   <= '1;
        r_rem   <= div_if.op_a_e;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (w_ovf) begin
        r_quo   <= {1'b1, {(XLEN-1){1'b0}}};
        r_rem   <= '0;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else begin
        r_quo   <= w_mag_a;
        r_rem   <= '0;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + 6'd1;
      r_rem <= w_rem_step;
      r_quo <= w_quo_step;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module      : tb_div_unit
// Description : Directed vector bench for div_unit, plus multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  div_unit_if #(.XLEN(32)) dif ();

  div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Drives one op starting just after a posedge and runs until div_done.
  // Leaves div_en_e high; the caller decides what the next cycle looks like.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int stall_cnt;
    logic [31:0] res;
    lat = -1;
    stall_cnt = 0;
    res = '0;
    dif.div_en_e = 1'b1;
    dif.funct3_e = f3;
    dif.op_a_e   = a;
    dif.op_b_e   = b;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (dif.div_stall) stall_cnt++;
      if (dif.div_done) begin
        lat = c;
        res = dif.div_result;
      end
      @(posedge clk);
      #1;
      if (lat >= 0) break;
    end
    check({name, " result"}, res, exp_res);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " stall cycles"}, 32'(stall_cnt), 32'(exp_lat));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n         = 1'b0;
    dif.div_en_e  = 1'b0;
    dif.funct3_e  = 3'b000;
    dif.op_a_e    = '0;
    dif.op_b_e    = '0;
    dif.flush_e   = 1'b0;

    vecs[0]  = '{F3_DIV,  32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{F3_REM,  32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{F3_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33};
    vecs[3]  = '{F3_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33};
    vecs[4]  = '{F3_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33};
    vecs[5]  = '{F3_DIV,  32'd7,          32'hFFFF_FFFD,  32'hFFFF_FFFE,  33};
    vecs[6]  = '{F3_REM,  32'd7,          32'hFFFF_FFFD,  32'd1,          33};
    vecs[7]  = '{F3_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[8]  = '{F3_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          33};
    vecs[9]  = '{F3_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[10] = '{F3_REMU, 32'd5,          32'd0,          32'd5,          1};
    vecs[11] = '{F3_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
    vecs[12] = '{F3_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[13] = '{F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[14] = '{F3_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};

    repeat (2) @(posedge clk);
    #1;
    check("reset stall",  32'(dif.div_stall), 32'd0);
    check("reset done",   32'(dif.div_done),  32'd0);
    check("reset result", dif.div_result,     32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
             vecs[i].exp_res, vecs[i].exp_lat);
      dif.div_en_e = 1'b0;
      @(posedge clk);
      #1;
    end

    // Back-to-back: second op is presented in the cycle right after div_done.
    run_op("b2b divu", F3_DIVU, 32'd10, 32'd3, 32'd3, 33);
    run_op("b2b remu", F3_REMU, 32'd10, 32'd3, 32'd1, 33);
    dif.div_en_e = 1'b0;
    @(posedge clk);
    #1;

    // Flush during CALC cycle 10.
    dif.div_en_e = 1'b1;
    dif.funct3_e = F3_DIV;
    dif.op_a_e   = 32'd100;
    dif.op_b_e   = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    dif.flush_e  = 1'b1;
    dif.div_en_e = 1'b0;
    @(posedge clk);
    #1;
    dif.flush_e = 1'b0;
    @(negedge clk);
    check("flush stall", 32'(dif.div_stall), 32'd0);
    begin
      int done_seen;
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (dif.div_done) done_seen++;
      end
      check("flush no done", 32'(done_seen), 32'd0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset during CALC cycle 20.
    dif.div_en_e = 1'b1;
    dif.funct3_e = F3_DIVU;
    dif.op_a_e   = 32'd1000;
    dif.op_b_e   = 32'd3;
    repeat (20) @(posedge clk);
    #1;
    check("pre-reset stall", 32'(dif.div_stall), 32'd1);
    dif.div_en_e = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async reset stall",  32'(dif.div_stall), 32'd0);
    check("async reset done",   32'(dif.div_done),  32'd0);
    check("async reset result", dif.div_result,     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post-reset div", F3_DIV, 32'd9, 32'd3, 32'd3, 33);
    dif.div_en_e = 1'b0;
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
